// File: rtl/fm_cmn_bfifo_pkg.sv
// fm_cmn_bfifo shared constants.
// Output-buffer sizing used by the FIFO and its interface.
package fm_cmn_bfifo_pkg;

  localparam int C_OBUF = 2;

  function automatic int f_cap(input int range);
    return (1 << range) + C_OBUF;
  endfunction

endpackage

// File: rtl/fm_cmn_bfifo_if.sv
// fm_cmn_bfifo handshake bundle.
// Names are from the FIFO's point of view; master drives i_*.
interface fm_cmn_bfifo_if #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4
);

  logic               i_clear;
  logic               i_wstrobe;
  logic [P_WIDTH-1:0] i_wdata;
  logic               o_wack;
  logic               o_rstrobe;
  logic [P_WIDTH-1:0] o_rdata;
  logic               i_rack;
  logic [P_RANGE+1:0] o_level;
  logic               o_empty;

  modport master (
    output i_clear,
    output i_wstrobe,
    output i_wdata,
    output i_rack,
    input  o_wack,
    input  o_rstrobe,
    input  o_rdata,
    input  o_level,
    input  o_empty
  );

  modport slave (
    input  i_clear,
    input  i_wstrobe,
    input  i_wdata,
    input  i_rack,
    output o_wack,
    output o_rstrobe,
    output o_rdata,
    output o_level,
    output o_empty
  );

endinterface

// File: rtl/fm_cmn_bram_01.sv
// Dual-port block RAM: write port plus registered,
// always-enabled read port (dpo).
module fm_cmn_bram_01 #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [P_RANGE-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_di,
  input  logic [P_RANGE-1:0] i_dpra,
  output logic [P_WIDTH-1:0] o_dpo
);

  localparam int P_DEPTH = 1 << P_RANGE;

  logic [P_WIDTH-1:0] r_mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_a] <= i_di;
    o_dpo <= r_mem[i_dpra];
  end

endmodule

// File: rtl/fm_cmn_bfifo.sv
// First-word-fall-through FIFO on block RAM with a
// 2-entry skid turning the free-running dpo into valid/ack.
module fm_cmn_bfifo
  import fm_cmn_bfifo_pkg::*;
#(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4
) (
  input  logic          clk_core,
  input  logic          rst_core,
  fm_cmn_bfifo_if.slave s_if
);

  localparam int P_LW = P_RANGE + 2;
  localparam logic [P_RANGE:0] C_FULL =
    {1'b1, {P_RANGE{1'b0}}};

  logic [P_RANGE-1:0] r_wp;
  logic [P_RANGE-1:0] r_rp;
  logic [P_RANGE:0]   r_cram;
  logic               r_v1;
  logic [1:0]         r_nout;
  logic [P_WIDTH-1:0] r_head;
  logic [P_WIDTH-1:0] r_spare;

  logic [P_WIDTH-1:0] w_dpo;
  logic               w_wack;
  logic               w_accw;
  logic               w_pop;
  logic               w_iss;
  logic [2:0]         w_pend;
  logic               w_ld_head;
  logic               w_ld_spare;
  logic               w_shift;

  assign w_wack = (r_cram != C_FULL) & ~s_if.i_clear;
  assign w_accw = s_if.i_wstrobe & w_wack;
  assign w_pop  = (r_nout != 2'd0) & s_if.i_rack;

  // Skid occupancy after this edge if nothing new issues.
  assign w_pend = {1'b0, r_nout} + {2'b0, r_v1}
                - {2'b0, w_pop};
  assign w_iss  = (r_cram != '0) & (w_pend < 3'(C_OBUF));

  assign w_ld_head  = r_v1 & ((r_nout == 2'd0) |
                     (w_pop & (r_nout == 2'd1)));
  assign w_ld_spare = r_v1 & ~w_ld_head;
  assign w_shift    = w_pop & (r_nout == 2'd2);

  fm_cmn_bram_01 #(
    .P_WIDTH (P_WIDTH),
    .P_RANGE (P_RANGE)
  ) u_ram (
    .clk    (clk_core),
    .i_we   (w_accw),
    .i_a    (r_wp),
    .i_di   (s_if.i_wdata),
    .i_dpra (r_rp),
    .o_dpo  (w_dpo)
  );

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cram <= '0;
      r_v1   <= 1'b0;
    end else if (s_if.i_clear) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cram <= '0;
      r_v1   <= 1'b0;
    end else begin
      if (w_accw) r_wp <= r_wp + 1'b1;
      if (w_iss)  r_rp <= r_rp + 1'b1;
      r_v1 <= w_iss;
      unique case ({w_accw, w_iss})
        2'b10:   r_cram <= r_cram + 1'b1;
        2'b01:   r_cram <= r_cram - 1'b1;
        default: r_cram <= r_cram;
      endcase
    end
  end

  // Clear drops occupancy but leaves the head data visible.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_nout  <= 2'd0;
      r_head  <= '0;
      r_spare <= '0;
    end else if (s_if.i_clear) begin
      r_nout  <= 2'd0;
    end else begin
      r_nout <= w_pend[1:0];
      unique case (1'b1)
        w_ld_head:  r_head  <= w_dpo;
        w_ld_spare: r_spare <= w_dpo;
        w_shift:    r_head  <= r_spare;
        default:    ;
      endcase
    end
  end

  assign s_if.o_wack    = w_wack;
  assign s_if.o_rstrobe = (r_nout != 2'd0);
  assign s_if.o_rdata   = r_head;
  assign s_if.o_level   = P_LW'(r_cram) + P_LW'(r_v1)
                        + P_LW'(r_nout);
  assign s_if.o_empty   = (s_if.o_level == '0);

endmodule

// File: tb/tb_fm_cmn_bfifo.sv
// Self-checking bench for fm_cmn_bfifo (depth 4, capacity 6).
// Table-driven fill/drain plus directed corner sequences.
module tb_fm_cmn_bfifo;

  logic clk_core;
  logic rst_core;
  int   n_cmp;
  int   n_bad;

  fm_cmn_bfifo_if #(.P_WIDTH(8), .P_RANGE(2)) bif ();

  fm_cmn_bfifo #(.P_WIDTH(8), .P_RANGE(2)) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .s_if     (bif.slave)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  typedef struct {
    logic       ws;
    logic [7:0] wd;
    logic       ra;
    logic       e_wack;
    logic       e_rs;
    logic [7:0] e_rd;
    logic [3:0] e_lvl;
    logic       c_rd;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic ws, input logic [7:0] wd,
                     input logic ra, input logic cl);
    @(negedge clk_core);
    bif.i_wstrobe = ws;
    bif.i_wdata   = wd;
    bif.i_rack    = ra;
    bif.i_clear   = cl;
    #1;
  endtask

  // Wait (bounded) for o_rstrobe; returns idle cycles spent.
  task automatic wait_rs(output int n);
    n = 0;
    while (!bif.o_rstrobe && n < 10) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
  endtask

  logic [7:0] q [$];
  int         mlvl;
  int         nw;
  logic       ws;
  logic       ra;
  logic [7:0] wd;
  logic [7:0] exp8;
  logic [3:0] elvl;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bif.i_clear   = 1'b0;
    bif.i_wstrobe = 1'b0;
    bif.i_wdata   = 8'h00;
    bif.i_rack    = 1'b0;
    rst_core      = 1'b1;

    //         ws wd     ra wack rs rd     lvl  c_rd
    tv[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    tv[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0};
    tv[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 1'b0};
    tv[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA0, 4'd3, 1'b1};
    tv[4]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA0, 4'd4, 1'b1};
    tv[5]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA0, 4'd5, 1'b1};
    tv[6]  = '{1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 8'hA0, 4'd6, 1'b1};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA0, 4'd6, 1'b1};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 4'd5, 1'b1};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 4'd4, 1'b1};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 4'd3, 1'b1};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 4'd2, 1'b1};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b1};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b1};

    repeat (2) @(negedge clk_core);
    rst_core = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_wack", bif.o_wack, 1);
      chk("idle_rs", bif.o_rstrobe, 0);
      chk("idle_lvl", bif.o_level, 0);
      chk("idle_empty", bif.o_empty, 1);
      chk("idle_rdata", bif.o_rdata, 0);
    end

    // Fill to capacity, overflow attempt, drain
    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].ws, tv[i].wd, tv[i].ra, 1'b0);
      chk($sformatf("tv%0d_wack", i), bif.o_wack, tv[i].e_wack);
      chk($sformatf("tv%0d_rs", i), bif.o_rstrobe, tv[i].e_rs);
      chk($sformatf("tv%0d_lvl", i), bif.o_level, tv[i].e_lvl);
      chk($sformatf("tv%0d_empty", i), bif.o_empty,
          tv[i].e_lvl == 4'd0);
      if (tv[i].c_rd)
        chk($sformatf("tv%0d_rd", i), bif.o_rdata, tv[i].e_rd);
    end

    // Streaming write+pop every cycle, 100 words
    for (int t = 0; t < 104; t++) begin
      wd = 8'(t);
      cyc(t < 100, wd, 1'b1, 1'b0);
      if (t < 3)        elvl = 4'(t);
      else if (t <= 100) elvl = 4'd3;
      else              elvl = 4'(103 - t);
      chk($sformatf("st%0d_lvl", t), bif.o_level, elvl);
      chk($sformatf("st%0d_rs", t), bif.o_rstrobe,
          (t >= 3) && (t <= 102));
      if (t >= 3 && t <= 102) begin
        exp8 = 8'(t - 3);
        chk($sformatf("st%0d_rd", t), bif.o_rdata, exp8);
      end
    end

    // Random traffic against a queue scoreboard
    mlvl = 0;
    for (int t = 0; t < 2000; t++) begin
      ws = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      cyc(ws, wd, ra, 1'b0);
      chk("rnd_lvl", bif.o_level, mlvl);
      chk("rnd_empty", bif.o_empty, mlvl == 0);
      if (bif.o_rstrobe && ra) begin
        chk("rnd_qne", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp8 = q.pop_front();
          chk("rnd_rd", bif.o_rdata, exp8);
          mlvl--;
        end
      end
      if (ws && bif.o_wack) begin
        q.push_back(wd);
        mlvl++;
      end
    end
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      if (bif.o_rstrobe) begin
        exp8 = q.pop_front();
        chk("drain_rd", bif.o_rdata, exp8);
      end
    end
    chk("drain_lost", q.size(), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_lvl", bif.o_level, 0);

    // Clear together with a pop and a write
    cyc(1'b1, 8'hB0, 1'b0, 1'b0);
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_pre_lvl", bif.o_level, 4);
    chk("clr_pre_rd", bif.o_rdata, 8'hB0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("clr_wack", bif.o_wack, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_lvl", bif.o_level, 0);
    chk("clr_rs", bif.o_rstrobe, 0);
    chk("clr_empty", bif.o_empty, 1);
    chk("clr_rd_hold", bif.o_rdata, 8'hB0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("clr_w55_ack", bif.o_wack, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    wait_rs(nw);
    chk("clr_lat", nw, 2);
    chk("clr_rd55", bif.o_rdata, 8'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_post_lvl", bif.o_level, 0);

    // Asynchronous reset mid-stream
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_pre_lvl", bif.o_level, 3);
    chk("rst_pre_rs", bif.o_rstrobe, 1);
    #1 rst_core = 1'b1;
    #1;
    chk("rst_rs", bif.o_rstrobe, 0);
    chk("rst_lvl", bif.o_level, 0);
    chk("rst_wack", bif.o_wack, 1);
    chk("rst_empty", bif.o_empty, 1);
    chk("rst_rd", bif.o_rdata, 0);
    @(negedge clk_core);
    rst_core = 1'b0;
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    wait_rs(nw);
    chk("rst_lat", nw, 2);
    chk("rst_rd66", bif.o_rdata, 8'h66);
    chk("rst_lvl1", bif.o_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
